csla_32: RTL and testbench
==========================

# csla_32

Registered 32-bit carry-select adder: adds two 32-bit operands and a carry-in, and presents the 32-bit sum and carry-out from an output register one clock after the operands are sampled. It is a datapath arithmetic primitive, used wherever a wide add must be faster than a plain ripple chain. It has no handshake; every clock edge captures a new result.

## Interface

- No parameters. Width is fixed at 32 and the block size is fixed at 4 bits.
- clk  input  1  rising-edge clock; one clock only.
- rst  input  1  reset, asynchronous and active-high; clears the output register.
- a  input  32  operand A, unsigned.
- b  input  32  operand B, unsigned.
- cin  input  1  carry-in into bit 0.
- sum  output  32  registered result, (a + b + cin) mod 2^32.
- cout  output  1  registered carry-out of bit 31.

## Operation

- The combinational core computes {cout_n, sum_n} = a + b + cin as a 33-bit unsigned result.
- The core is split into eight 4-bit blocks: block k covers bits [4k+3:4k].
- Block 0 is a 4-bit ripple-carry adder fed by cin.
- Blocks 1–7 each contain two 4-bit ripple-carry adders:
  - one with carry-in fixed at 0;
  - one with carry-in fixed at 1.
- A 2:1 mux selects each block's 4 sum bits and its carry-out, using the selected carry-out of block k−1 as the select.
- The selected carry-out of block 7 is cout_n.
- Each ripple adder is built from full adders: s = x^y^c, co = (x&y)|(c&(x^y)).
- The result must match plain binary addition exactly for all 2^65 input combinations. No overflow or sign handling is done; this is unsigned only.
- Output register:
  - on a rising clk edge, sum <= sum_n and cout <= cout_n;
  - while rst = 1, sum = 0 and cout = 0.

## Timing

- Latency is 1 cycle. Inputs present before rising edge N appear on sum/cout after edge N. Throughput is one add per cycle.
- Reset:
  - asserting rst forces sum = 32'h0 and cout = 0 immediately, with no clock needed;
  - while rst is held, edges are ignored;
  - after rst deasserts, the first rising edge captures the current inputs.
- Reset arriving mid-operation discards the pending result; nothing is queued.
- If the inputs change between edges, only the values present at the edge are captured.
- The combinational path is a → 4-bit ripple → 7 mux stages → register. It must meet a single clk period.

## Test plan

- Reset: drive a = b = 32'hFFFFFFFF and cin = 1, then assert rst -> sum = 0 and cout = 0 immediately, with no edge required. Deassert rst and give one edge -> sum = 32'hFFFFFFFF, cout = 1.
- Zero: a = 0, b = 0, cin = 0 -> after 1 edge, sum = 32'h00000000, cout = 0.
- Inter-block carry: a = 32'h0000FFFF, b = 32'h00000001, cin = 0 -> sum = 32'h00010000, cout = 0.
- Full wrap: a = 32'hFFFFFFFF, b = 32'h00000001, cin = 1 -> sum = 32'h00000001, cout = 1.
- Alternating patterns:
  - a = 32'hAAAAAAAA, b = 32'h55555555, cin = 0 -> sum = 32'hFFFFFFFF, cout = 0;
  - same a and b with cin = 1 -> sum = 32'h00000000, cout = 1.
- Mixed operands: a = 32'h12345678, b = 32'h87645201, cin = 1 -> sum = 32'h9998A87A, cout = 0. Follow with back-to-back random vectors, one per cycle, each checked against a 33-bit reference sum one cycle later.

Source files
------------

// File: rtl/csla_32_if.sv
// rtl/csla_32_if.sv - operand/result bundle for the registered 32-bit carry-select adder
interface csla_32_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/csla_32.sv
// rtl/csla_32.sv - registered 32-bit carry-select adder, eight 4-bit blocks
module csla_32 (
    input  logic      clk,
    input  logic      rst,
    csla_32_if.slave  bus
);

    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
        logic [3:0] s;
        logic       cc;
        cc = c;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {cc, s};
    endfunction

    logic [4:0]  blk0;
    logic [4:0]  r0 [1:7];
    logic [4:0]  r1 [1:7];
    logic [31:0] sum_n;
    logic        cout_n;
    logic        sel;

    assign blk0 = ripple4(bus.a[3:0], bus.b[3:0], bus.cin);

    // Both carry hypotheses per block are resolved in parallel; only the mux chain is serial.
    for (genvar k = 1; k < 8; k++) begin : g_blk
        assign r0[k] = ripple4(bus.a[4*k +: 4], bus.b[4*k +: 4], 1'b0);
        assign r1[k] = ripple4(bus.a[4*k +: 4], bus.b[4*k +: 4], 1'b1);
    end

    always_comb begin
        sum_n       = '0;
        sel         = blk0[4];
        sum_n[3:0]  = blk0[3:0];
        for (int k = 1; k < 8; k++) begin
            if (sel) begin
                sum_n[4*k +: 4] = r1[k][3:0];
                sel             = r1[k][4];
            end else begin
                sum_n[4*k +: 4] = r0[k][3:0];
                sel             = r0[k][4];
            end
        end
        cout_n = sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= sum_n;
            bus.cout <= cout_n;
        end
    end

endmodule

// File: tb/tb_csla_32.sv
// tb/tb_csla_32.sv - self-checking bench for csla_32 against a 33-bit arithmetic reference
module tb_csla_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    csla_32_if bus ();

    csla_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: whatever was on the inputs at the last non-reset edge, added as 33-bit unsigned.
    logic [32:0] exp_res = 33'h0;
    always @(posedge clk or posedge rst) begin
        if (rst)
            exp_res <= 33'h0;
        else
            exp_res <= {1'b0, bus.a} + {1'b0, bus.b} + {32'h0, bus.cin};
    end

    always @(negedge clk) begin
        checks++;
        if ({bus.cout, bus.sum} !== exp_res) begin
            failures++;
            $display("FAIL model t=%0t got cout=%0b sum=%08h want cout=%0b sum=%08h",
                     $time, bus.cout, bus.sum, exp_res[32], exp_res[31:0]);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] es, input logic ec);
        checks++;
        if (bus.sum !== es || bus.cout !== ec) begin
            failures++;
            $display("FAIL %s got cout=%0b sum=%08h want cout=%0b sum=%08h",
                     name, bus.cout, bus.sum, ec, es);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        bus.a   = av;
        bus.b   = bv;
        bus.cin = cv;
    endtask

    task automatic directed(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic cv, input logic [31:0] es, input logic ec);
        drive(av, bv, cv);
        @(posedge clk);
        #1;
        check_lit(name, es, ec);
    endtask

    initial begin
        drive(32'h0, 32'h0, 1'b0);
        #1;
        check_lit("reset_initial", 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Load a nonzero result, then reset asynchronously mid-cycle.
        directed("preload", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_lit("reset_async", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_lit("reset_hold", 32'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_lit("reset_release", 32'hFFFFFFFF, 1'b1);

        directed("zero",       32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        directed("blk_carry",  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);
        directed("full_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1);
        directed("alt_cin0",   32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0);
        directed("alt_cin1",   32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1);
        directed("mixed",      32'h12345678, 32'h87645201, 1'b1, 32'h9998A87A, 1'b0);
        directed("cin_only",   32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0);
        directed("top_carry",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        directed("ripple_all", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);

        // Inputs that change between edges: only the value at the edge is captured.
        drive(32'h11111111, 32'h22222222, 1'b0);
        #3 drive(32'h00000010, 32'h00000020, 1'b1);
        @(posedge clk);
        #1;
        check_lit("last_at_edge", 32'h00000031, 1'b0);

        // Reset with a pending result discards it.
        drive(32'h0F0F0F0F, 32'h01010101, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_lit("reset_discard", 32'h0, 1'b0);
        rst = 1'b0;
        directed("post_discard", 32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0);

        for (int i = 0; i < 60; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
